// File: rtl/mem_stage_async_if.sv
// EX -> MEM pipeline bus for the asynchronous MEM stage.
//   master : EX side, drives the instruction fields and es2ms_valid
//   slave  : MEM side, drives ms_allowin back to EX
interface mem_stage_async_if #(
    parameter int XLEN      = 32,
    parameter int PAYLOAD_W = 118
);
    logic                 es2ms_valid;
    logic                 ms_allowin;
    logic                 es2ms_rf_we;
    logic [4:0]           es2ms_rf_waddr;
    logic [XLEN-1:0]      es2ms_result;
    logic                 es2ms_is_load;
    logic [1:0]           es2ms_ld_size;
    logic                 es2ms_ld_sign;
    logic                 es2ms_mem_req;
    logic                 es2ms_ex;
    logic [PAYLOAD_W-1:0] es2ms_payload;

    modport master (
        output es2ms_valid, es2ms_rf_we, es2ms_rf_waddr, es2ms_result,
               es2ms_is_load, es2ms_ld_size, es2ms_ld_sign, es2ms_mem_req,
               es2ms_ex, es2ms_payload,
        input  ms_allowin
    );

    modport slave (
        input  es2ms_valid, es2ms_rf_we, es2ms_rf_waddr, es2ms_result,
               es2ms_is_load, es2ms_ld_size, es2ms_ld_sign, es2ms_mem_req,
               es2ms_ex, es2ms_payload,
        output ms_allowin
    );
endinterface

// File: rtl/mem_stage_async.sv
// MEM pipeline stage with a variable-latency data memory.
// Holds the instruction until its data_ok arrives, buffers a response that
// arrives while WB is stalled, extracts/sign-extends load data, drops
// responses belonging to flushed instructions, and drives the ID forwarding
// and interlock bus.
// Ports:
//   clk, resetn          clock, synchronous active-low reset
//   es_bus (slave)       EX -> MEM instruction bus and ms_allowin
//   es_req_inflight      EX holds an accepted request not yet in MEM
//   data_sram_*          response strobe and data
//   ms2ws_*, ws_allowin  MEM -> WB handshake and fields
//   ms_fwd_*             forwarding / load-use interlock to ID
//   ms_ex, ws_ex         exception out, flush in
module mem_stage_async #(
    parameter int XLEN      = 32,
    parameter int PAYLOAD_W = 118,
    parameter int DISCARD_W = 2
) (
    input  logic                 clk,
    input  logic                 resetn,
    mem_stage_async_if.slave     es_bus,
    input  logic                 es_req_inflight,
    input  logic                 data_sram_data_ok,
    input  logic [XLEN-1:0]      data_sram_rdata,
    output logic                 ms2ws_valid,
    input  logic                 ws_allowin,
    output logic                 ms2ws_rf_we,
    output logic [4:0]           ms2ws_rf_waddr,
    output logic [XLEN-1:0]      ms2ws_rf_wdata,
    output logic [XLEN-1:0]      ms2ws_result,
    output logic [PAYLOAD_W-1:0] ms2ws_payload,
    output logic                 ms_fwd_we,
    output logic [4:0]           ms_fwd_waddr,
    output logic [XLEN-1:0]      ms_fwd_wdata,
    output logic                 ms_fwd_busy,
    output logic                 ms_ex,
    input  logic                 ws_ex
);
    localparam int OFF_W = $clog2(XLEN/8);

    logic                 ms_valid;
    logic                 ms_allowin;
    logic                 ms_ready_go;
    logic                 live_ok;
    logic                 rf_we_r;
    logic [4:0]           rf_waddr_r;
    logic [XLEN-1:0]      result_r;
    logic                 is_load_r;
    logic [1:0]           ld_size_r;
    logic                 ld_sign_r;
    logic                 mem_req_r;
    logic                 ex_r;
    logic [PAYLOAD_W-1:0] payload_r;
    logic                 data_got;
    logic [XLEN-1:0]      data_buf;
    logic [DISCARD_W-1:0] discard_cnt;
    logic [DISCARD_W-1:0] discard_inc;
    logic [DISCARD_W-1:0] discard_dec;
    logic [XLEN-1:0]      ld_data;
    logic [XLEN-1:0]      ld_shift;
    logic [XLEN-1:0]      ld_mask;
    logic                 ld_top;
    logic [XLEN-1:0]      ld_ext;
    logic [XLEN-1:0]      rf_wdata;

    // A strobe only belongs to the current instruction once every stale
    // response owed to flushed instructions has been drained.
    assign live_ok     = data_sram_data_ok & (discard_cnt == '0);
    assign ms_ready_go = ex_r | ~mem_req_r | data_got | live_ok;
    assign ms_allowin  = ~ms_valid | (ms_ready_go & ws_allowin);
    assign es_bus.ms_allowin = ms_allowin;
    assign ms2ws_valid = ms_valid & ms_ready_go;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            ms_valid <= 1'b0;
        end else if (ws_ex) begin
            ms_valid <= 1'b0;
        end else if (ms_allowin) begin
            ms_valid <= es_bus.es2ms_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            rf_we_r    <= 1'b0;
            rf_waddr_r <= '0;
            result_r   <= '0;
            is_load_r  <= 1'b0;
            ld_size_r  <= '0;
            ld_sign_r  <= 1'b0;
            mem_req_r  <= 1'b0;
            ex_r       <= 1'b0;
            payload_r  <= '0;
        end else if (es_bus.es2ms_valid & ms_allowin & ~ws_ex) begin
            rf_we_r    <= es_bus.es2ms_rf_we;
            rf_waddr_r <= es_bus.es2ms_rf_waddr;
            result_r   <= es_bus.es2ms_result;
            is_load_r  <= es_bus.es2ms_is_load;
            ld_size_r  <= es_bus.es2ms_ld_size;
            ld_sign_r  <= es_bus.es2ms_ld_sign;
            mem_req_r  <= es_bus.es2ms_mem_req;
            ex_r       <= es_bus.es2ms_ex;
            payload_r  <= es_bus.es2ms_payload;
        end
    end

    // A response that cannot be handed to WB immediately is parked here;
    // ms_allowin covers both "instruction leaves" and "new one enters".
    always_ff @(posedge clk) begin
        if (!resetn) begin
            data_got <= 1'b0;
            data_buf <= '0;
        end else if (ws_ex | ms_allowin) begin
            data_got <= 1'b0;
        end else if (ms_valid & mem_req_r & ~data_got & live_ok & ~ws_allowin) begin
            data_got <= 1'b1;
            data_buf <= data_sram_rdata;
        end
    end

    // On a flush, every request still owed a response becomes stale: the
    // MEM instruction's (unless its response is arriving right now) and
    // the one EX already issued.
    always_comb begin
        discard_inc = '0;
        if (ws_ex) begin
            discard_inc = DISCARD_W'(ms_valid & mem_req_r & ~data_got & ~live_ok)
                        + DISCARD_W'(es_req_inflight);
        end
        discard_dec = DISCARD_W'(data_sram_data_ok & (discard_cnt != '0));
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            discard_cnt <= '0;
        end else begin
            discard_cnt <= discard_cnt + discard_inc - discard_dec;
        end
    end

    assign ld_data  = data_got ? data_buf : data_sram_rdata;
    assign ld_shift = ld_data >> {result_r[OFF_W-1:0], 3'b000};

    // Mask selects the loaded width; bits above it take the extension bit.
    always_comb begin
        ld_mask = '0;
        ld_top  = 1'b0;
        case (ld_size_r)
            2'd0: begin ld_mask = XLEN'(8'hff);         ld_top = ld_shift[7];  end
            2'd1: begin ld_mask = XLEN'(16'hffff);      ld_top = ld_shift[15]; end
            2'd2: begin ld_mask = XLEN'(32'hffff_ffff); ld_top = ld_shift[31]; end
            default: begin
                if (XLEN == 64) begin
                    ld_mask = '1;
                    ld_top  = ld_shift[XLEN-1];
                end
            end
        endcase
        ld_ext = (ld_shift & ld_mask) | ({XLEN{ld_sign_r & ld_top}} & ~ld_mask);
    end

    assign rf_wdata       = is_load_r ? ld_ext : result_r;
    assign ms2ws_rf_we    = rf_we_r & ~ex_r;
    assign ms2ws_rf_waddr = rf_waddr_r;
    assign ms2ws_rf_wdata = rf_wdata;
    assign ms2ws_result   = result_r;
    assign ms2ws_payload  = payload_r;
    assign ms_fwd_we      = ms_valid & rf_we_r;
    assign ms_fwd_waddr   = rf_waddr_r;
    assign ms_fwd_wdata   = rf_wdata;
    assign ms_fwd_busy    = ms_valid & is_load_r & rf_we_r & ~ms_ready_go;
    assign ms_ex          = ms_valid & ex_r;
endmodule

// File: tb/tb_mem_stage_async.sv
module tb_mem_stage_async;
    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    mem_stage_async_if #(.XLEN(32), .PAYLOAD_W(118)) es32 ();
    mem_stage_async_if #(.XLEN(64), .PAYLOAD_W(118)) es64 ();

    logic         infl32, d_ok32, wsa32, wsex32;
    logic [31:0]  rdata32;
    logic         v32, rfwe32, fwe32, busy32, ex32;
    logic [4:0]   waddr32, fwa32;
    logic [31:0]  wdata32, res32, fwd32;
    logic [117:0] pay32;

    logic         infl64, d_ok64, wsa64, wsex64;
    logic [63:0]  rdata64;
    logic         v64, rfwe64, fwe64, busy64, ex64;
    logic [4:0]   waddr64, fwa64;
    logic [63:0]  wdata64, res64, fwd64;
    logic [117:0] pay64;

    mem_stage_async #(.XLEN(32), .PAYLOAD_W(118), .DISCARD_W(2)) dut32 (
        .clk(clk), .resetn(resetn), .es_bus(es32), .es_req_inflight(infl32),
        .data_sram_data_ok(d_ok32), .data_sram_rdata(rdata32),
        .ms2ws_valid(v32), .ws_allowin(wsa32), .ms2ws_rf_we(rfwe32),
        .ms2ws_rf_waddr(waddr32), .ms2ws_rf_wdata(wdata32), .ms2ws_result(res32),
        .ms2ws_payload(pay32), .ms_fwd_we(fwe32), .ms_fwd_waddr(fwa32),
        .ms_fwd_wdata(fwd32), .ms_fwd_busy(busy32), .ms_ex(ex32), .ws_ex(wsex32)
    );

    mem_stage_async #(.XLEN(64), .PAYLOAD_W(118), .DISCARD_W(2)) dut64 (
        .clk(clk), .resetn(resetn), .es_bus(es64), .es_req_inflight(infl64),
        .data_sram_data_ok(d_ok64), .data_sram_rdata(rdata64),
        .ms2ws_valid(v64), .ws_allowin(wsa64), .ms2ws_rf_we(rfwe64),
        .ms2ws_rf_waddr(waddr64), .ms2ws_rf_wdata(wdata64), .ms2ws_result(res64),
        .ms2ws_payload(pay64), .ms_fwd_we(fwe64), .ms_fwd_waddr(fwa64),
        .ms_fwd_wdata(fwd64), .ms_fwd_busy(busy64), .ms_ex(ex64), .ws_ex(wsex64)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic put32(input logic v, input logic we, input logic [4:0] wa,
                         input logic [31:0] res, input logic ld, input logic [1:0] sz,
                         input logic sg, input logic mr, input logic ex);
        es32.es2ms_valid    = v;
        es32.es2ms_rf_we    = we;
        es32.es2ms_rf_waddr = wa;
        es32.es2ms_result   = res;
        es32.es2ms_is_load  = ld;
        es32.es2ms_ld_size  = sz;
        es32.es2ms_ld_sign  = sg;
        es32.es2ms_mem_req  = mr;
        es32.es2ms_ex       = ex;
        es32.es2ms_payload  = {86'h0, res};
        infl32 = v & mr;
    endtask

    task automatic put64(input logic v, input logic we, input logic [4:0] wa,
                         input logic [63:0] res, input logic ld, input logic [1:0] sz,
                         input logic sg, input logic mr);
        es64.es2ms_valid    = v;
        es64.es2ms_rf_we    = we;
        es64.es2ms_rf_waddr = wa;
        es64.es2ms_result   = res;
        es64.es2ms_is_load  = ld;
        es64.es2ms_ld_size  = sz;
        es64.es2ms_ld_sign  = sg;
        es64.es2ms_mem_req  = mr;
        es64.es2ms_ex       = 1'b0;
        es64.es2ms_payload  = {54'h0, res};
        infl64 = v & mr;
    endtask

    // Reference load: take 8<<size bits starting at byte offset, extend.
    function automatic logic [63:0] ref_load(input logic [63:0] rdata, input int off,
                                             input int size, input bit sgn, input int xlen);
        int nbits;
        logic [63:0] v, m;
        nbits = 8 << size;
        if (size == 3 && xlen == 32) return 64'h0;
        v = rdata >> (off * 8);
        m = (nbits == 64) ? {64{1'b1}} : ((64'd1 << nbits) - 64'd1);
        v = v & m;
        if (sgn && v[nbits-1]) v = v | ~m;
        if (xlen == 32) v[63:32] = 32'h0;
        return v;
    endfunction

    typedef struct {
        int           id;
        logic         rf_we;
        logic [4:0]   waddr;
        logic [31:0]  result;
        logic         is_load;
        logic [1:0]   size;
        logic         sign;
        logic         mem_req;
        logic         ex;
        logic [117:0] payload;
        logic [31:0]  exp_wdata;
    } ins_t;

    typedef struct {
        int          id;
        logic [31:0] rdata;
        int          wait_c;
        bit          stale;
    } rsp_t;

    rsp_t rq[$];
    ins_t exq, occ;
    bit   ex_v, m_v, m_got;
    int   nid, retired;

    function automatic int nstale();
        int n = 0;
        foreach (rq[i]) if (rq[i].stale) n++;
        return n;
    endfunction

    task automatic gen_ins;
        int k;
        logic [31:0]  rd;
        logic [127:0] p;
        k = $urandom_range(4);
        p = {$urandom, $urandom, $urandom, $urandom};
        rd = $urandom;
        exq.id      = nid;
        nid++;
        exq.result  = $urandom;
        exq.payload = p[117:0];
        exq.waddr   = 5'($urandom_range(31));
        exq.rf_we   = 1'b1;
        exq.is_load = 1'b0;
        exq.size    = 2'd0;
        exq.sign    = 1'b0;
        exq.mem_req = 1'b0;
        exq.ex      = 1'b0;
        case (k)
            0, 1: begin
                exq.is_load = 1'b1;
                exq.mem_req = 1'b1;
                exq.size    = 2'($urandom_range(3));
                exq.sign    = 1'($urandom_range(1));
                exq.rf_we   = ($urandom_range(3) != 0);
            end
            2: begin exq.mem_req = 1'b1; exq.rf_we = 1'b0; end
            3: exq.rf_we = 1'($urandom_range(1));
            default: exq.ex = 1'b1;
        endcase
        exq.exp_wdata = exq.is_load
            ? 32'(ref_load(64'(rd), int'(exq.result[1:0]), int'(exq.size), exq.sign, 32))
            : exq.result;
        if (exq.mem_req) rq.push_back('{exq.id, rd, int'($urandom_range(1, 5)), 1'b0});
        ex_v = 1'b1;
    endtask

    initial begin
        bit live, rdy, e_allow;
        put32(0, 0, 0, 0, 0, 0, 0, 0, 0);
        put64(0, 0, 0, 0, 0, 0, 0, 0);
        d_ok32 = 0; rdata32 = '0; wsa32 = 1; wsex32 = 0;
        d_ok64 = 0; rdata64 = '0; wsa64 = 1; wsex64 = 0;
        resetn = 0;
        cyc; cyc;
        chk("rst_valid", 64'(v32), 64'h0);
        chk("rst_busy", 64'(busy32), 64'h0);
        chk("rst_fwd_we", 64'(fwe32), 64'h0);
        chk("rst_ex", 64'(ex32), 64'h0);
        chk("rst_wdata", 64'(wdata32), 64'h0);
        chk("rst_allowin", 64'(es32.ms_allowin), 64'h1);
        chk("rst_valid64", 64'(v64), 64'h0);
        resetn = 1;

        // signed byte load, response after three wait cycles
        cyc; put32(1, 1, 5, 32'h1003, 1, 0, 1, 1, 0);
        #1 chk("t1_allowin", 64'(es32.ms_allowin), 64'h1);
        for (int i = 0; i < 3; i++) begin
            cyc; put32(0, 0, 0, 0, 0, 0, 0, 0, 0);
            #1 chk("t1_busy", 64'(busy32), 64'h1);
            chk("t1_wait_valid", 64'(v32), 64'h0);
        end
        cyc; d_ok32 = 1; rdata32 = 32'h80FF_1234;
        #1 chk("t1_valid", 64'(v32), 64'h1);
        chk("t1_wdata", 64'(wdata32), 64'hFFFF_FF80);
        chk("t1_busy_done", 64'(busy32), 64'h0);
        chk("t1_waddr", 64'(waddr32), 64'h5);
        chk("t1_fwd_wdata", 64'(fwd32), 64'hFFFF_FF80);
        cyc; d_ok32 = 0;
        #1 chk("t1_gone", 64'(v32), 64'h0);

        // unsigned half load, response while WB stalled
        cyc; put32(1, 1, 6, 32'h2002, 1, 1, 0, 1, 0);
        cyc; put32(0, 0, 0, 0, 0, 0, 0, 0, 0);
        d_ok32 = 1; rdata32 = 32'hBEEF_0000; wsa32 = 0;
        #1 chk("t2_valid_live", 64'(v32), 64'h1);
        chk("t2_hold", 64'(es32.ms_allowin), 64'h0);
        chk("t2_wdata_live", 64'(wdata32), 64'h0000_BEEF);
        cyc; d_ok32 = 0; rdata32 = 32'h1234_5678;
        #1 chk("t2_wdata_buf", 64'(wdata32), 64'h0000_BEEF);
        chk("t2_valid_buf", 64'(v32), 64'h1);
        cyc; wsa32 = 1;
        #1 chk("t2_wdata_release", 64'(wdata32), 64'h0000_BEEF);
        chk("t2_allowin", 64'(es32.ms_allowin), 64'h1);
        cyc;
        #1 chk("t2_gone", 64'(v32), 64'h0);

        // flush with a waiting load plus one request in flight from EX
        cyc; put32(1, 1, 7, 32'h3000, 1, 2, 0, 1, 0);
        cyc; put32(1, 1, 8, 32'h3100, 1, 2, 0, 1, 0); wsex32 = 1;
        #1 chk("t3_busy", 64'(busy32), 64'h1);
        cyc; wsex32 = 0; put32(1, 1, 10, 32'h3204, 1, 2, 0, 1, 0);
        d_ok32 = 1; rdata32 = 32'hDEAD_0001;
        #1 chk("t3_flushed", 64'(v32), 64'h0);
        chk("t3_allowin", 64'(es32.ms_allowin), 64'h1);
        cyc; put32(0, 0, 0, 0, 0, 0, 0, 0, 0); rdata32 = 32'hDEAD_0002;
        #1 chk("t3_drop2_busy", 64'(busy32), 64'h1);
        chk("t3_drop2_valid", 64'(v32), 64'h0);
        cyc; rdata32 = 32'hCAFE_F00D;
        #1 chk("t3_valid", 64'(v32), 64'h1);
        chk("t3_wdata", 64'(wdata32), 64'hCAFE_F00D);
        chk("t3_waddr", 64'(waddr32), 64'd10);
        cyc; d_ok32 = 0;
        #1 chk("t3_gone", 64'(v32), 64'h0);

        // flush coincident with the MEM load's own response
        cyc; put32(1, 1, 11, 32'h4000, 1, 2, 0, 1, 0);
        cyc; put32(0, 0, 0, 0, 0, 0, 0, 0, 0);
        d_ok32 = 1; rdata32 = 32'h5555_AAAA; wsex32 = 1; wsa32 = 0;
        cyc; d_ok32 = 0; wsex32 = 0; wsa32 = 1;
        #1 chk("t4_flushed", 64'(v32), 64'h0);
        chk("t4_allowin", 64'(es32.ms_allowin), 64'h1);
        put32(1, 1, 12, 32'h4001, 1, 0, 0, 1, 0);
        cyc; put32(0, 0, 0, 0, 0, 0, 0, 0, 0); d_ok32 = 1; rdata32 = 32'h0000_A500;
        #1 chk("t4_no_discard", 64'(v32), 64'h1);
        chk("t4_wdata", 64'(wdata32), 64'h0000_00A5);
        cyc; d_ok32 = 0;
        #1 chk("t4_gone", 64'(v32), 64'h0);

        // store waits for data_ok, ALU op passes through
        cyc; put32(1, 0, 0, 32'h5000, 0, 2, 0, 1, 0);
        cyc; put32(1, 1, 13, 32'h1234_5678, 0, 0, 0, 0, 0);
        #1 chk("t5_store_hold", 64'(es32.ms_allowin), 64'h0);
        chk("t5_store_wait", 64'(v32), 64'h0);
        chk("t5_store_busy", 64'(busy32), 64'h0);
        cyc; d_ok32 = 1; rdata32 = 32'h0BAD_0BAD;
        #1 chk("t5_store_done", 64'(v32), 64'h1);
        chk("t5_store_rfwe", 64'(rfwe32), 64'h0);
        chk("t5_accept_alu", 64'(es32.ms_allowin), 64'h1);
        cyc; d_ok32 = 0; put32(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1 chk("t5_alu_valid", 64'(v32), 64'h1);
        chk("t5_alu_wdata", 64'(wdata32), 64'h1234_5678);
        chk("t5_alu_busy", 64'(busy32), 64'h0);
        chk("t5_alu_fwd_we", 64'(fwe32), 64'h1);
        chk("t5_alu_fwd_wdata", 64'(fwd32), 64'h1234_5678);

        // excepting load never waits for data
        put32(1, 1, 14, 32'h6000, 1, 0, 0, 1, 1);
        cyc; put32(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1 chk("t5_ex", 64'(ex32), 64'h1);
        chk("t5_ex_valid", 64'(v32), 64'h1);
        chk("t5_ex_rfwe", 64'(rfwe32), 64'h0);
        chk("t5_ex_busy", 64'(busy32), 64'h0);
        cyc;
        #1 chk("t5_ex_gone", 64'(ex32), 64'h0);

        // XLEN=64: signed word at offset 4, then reset while waiting
        cyc; put64(1, 1, 9, 64'h5004, 1, 2, 1, 1);
        cyc; put64(0, 0, 0, 0, 0, 0, 0, 0);
        #1 chk("t6_busy", 64'(busy64), 64'h1);
        cyc; d_ok64 = 1; rdata64 = 64'h8000_0001_0000_0000;
        #1 chk("t6_valid", 64'(v64), 64'h1);
        chk("t6_wdata", wdata64, 64'hFFFF_FFFF_8000_0001);
        cyc; d_ok64 = 0; put64(1, 1, 3, 64'h6000, 1, 3, 0, 1);
        cyc; put64(0, 0, 0, 0, 0, 0, 0, 0);
        #1 chk("t6_wait2", 64'(busy64), 64'h1);
        resetn = 0;
        cyc;
        #1 chk("t6_rst_valid", 64'(v64), 64'h0);
        chk("t6_rst_busy", 64'(busy64), 64'h0);
        chk("t6_rst_wdata", wdata64, 64'h0);
        chk("t6_rst_waddr", 64'(fwa64), 64'h0);
        chk("t6_rst_fwd_we", 64'(fwe64), 64'h0);
        chk("t6_rst_payload", 64'(pay64 == '0), 64'h1);
        resetn = 1;

        // randomized traffic on the 32-bit stage against the transaction model
        m_v = 0; m_got = 0; ex_v = 0; nid = 0; retired = 0;
        rq.delete();
        cyc;
        put32(0, 0, 0, 0, 0, 0, 0, 0, 0);
        d_ok32 = 0; wsa32 = 1; wsex32 = 0;
        for (int c = 0; c < 3000; c++) begin
            #1;
            live    = d_ok32 && rq.size() > 0 && !rq[0].stale;
            rdy     = m_v && (occ.ex || !occ.mem_req || m_got || live);
            e_allow = !m_v || (rdy && wsa32);
            chk("r_allowin", 64'(es32.ms_allowin), 64'(e_allow));
            chk("r_valid", 64'(v32), 64'(rdy));
            chk("r_busy", 64'(busy32), 64'(m_v && occ.is_load && occ.rf_we && !rdy));
            chk("r_ms_ex", 64'(ex32), 64'(m_v && occ.ex));
            chk("r_fwd_we", 64'(fwe32), 64'(m_v && occ.rf_we));
            if (rdy) begin
                chk("r_wdata", 64'(wdata32), 64'(occ.exp_wdata));
                chk("r_fwd_wdata", 64'(fwd32), 64'(occ.exp_wdata));
                chk("r_waddr", 64'(waddr32), 64'(occ.waddr));
                chk("r_rf_we", 64'(rfwe32), 64'(occ.rf_we && !occ.ex));
                chk("r_result", 64'(res32), 64'(occ.result));
                chk("r_payload", 64'(pay32 == occ.payload), 64'h1);
            end
            @(posedge clk);
            if (rdy && wsa32 && !wsex32) retired++;
            if (d_ok32) void'(rq.pop_front());
            if (wsex32) begin
                if (m_v && occ.mem_req && !m_got && !live)
                    foreach (rq[i]) if (rq[i].id == occ.id) rq[i].stale = 1;
                if (ex_v && exq.mem_req)
                    foreach (rq[i]) if (rq[i].id == exq.id) rq[i].stale = 1;
                m_v = 0; m_got = 0; ex_v = 0;
            end else if (e_allow) begin
                m_v = ex_v; occ = exq; m_got = 0; ex_v = 0;
            end else if (live) begin
                m_got = 1;
            end
            assert (nstale() <= 3);
            foreach (rq[i]) rq[i].wait_c--;
            #1;
            if (!ex_v && $urandom_range(2) != 0) gen_ins();
            put32(ex_v, exq.rf_we, exq.waddr, exq.result, exq.is_load, exq.size,
                  exq.sign, exq.mem_req, exq.ex);
            es32.es2ms_payload = exq.payload;
            es32.es2ms_valid = ex_v;
            infl32 = ex_v && exq.mem_req;
            d_ok32 = rq.size() > 0 && rq[0].wait_c <= 0
                     && (rq[0].stale || (m_v && occ.id == rq[0].id))
                     && $urandom_range(3) != 0;
            rdata32 = d_ok32 ? rq[0].rdata : $urandom;
            wsa32 = ($urandom_range(3) != 0);
            wsex32 = ($urandom_range(24) == 0) && nstale() <= 1;
        end
        chk("r_progress", 64'(retired > 100), 64'h1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/mem_stage_async.md
Name: mem_stage_async

Overview:
- Parametrised next-generation MEM pipeline stage for the in-order 5-stage CPU; sits between the EX and WB stages.
- Unlike the fixed single-cycle MEM stage, data memory responds with a `data_ok` handshake an unknown number of cycles after the request, so the stage must stall for it.
- Stage holds the instruction until data returns, buffers early responses, and extracts/sign-extends loads for XLEN 32 or 64.
- Stage discards stale responses that belong to flushed instructions, and drives the forwarding/interlock bus to ID.

Parameters:
- XLEN, 32, datapath width; legal values 32 or 64.
- PAYLOAD_W, 118, width of the opaque pass-through bus (csr info, exception code, pc, ...).
- DISCARD_W, 2, width of the stale-response discard counter.

Ports:
- clk  in  1  clock
- resetn  in  1  reset
- es2ms_valid  in  1  EX holds a valid instruction
- ms_allowin  out  1  MEM can accept from EX
- es2ms_rf_we  in  1  instruction writes the register file
- es2ms_rf_waddr  in  5  destination register
- es2ms_result  in  XLEN  ALU result / memory address
- es2ms_is_load  in  1  instruction is a load
- es2ms_ld_size  in  2  0 byte, 1 half, 2 word, 3 dword (XLEN=64 only)
- es2ms_ld_sign  in  1  sign-extend the load
- es2ms_mem_req  in  1  a data request was accepted for this instruction (load or store)
- es2ms_ex  in  1  instruction carries an exception
- es2ms_payload  in  PAYLOAD_W  pass-through fields
- es_req_inflight  in  1  EX has an accepted request whose instruction has not yet entered MEM
- data_sram_data_ok  in  1  response strobe
- data_sram_rdata  in  XLEN  response data
- ms2ws_valid  out  1  valid to WB
- ws_allowin  in  1  WB can accept
- ms2ws_rf_we  out  1  WB register-file write enable
- ms2ws_rf_waddr  out  5  WB destination register
- ms2ws_rf_wdata  out  XLEN  WB write data
- ms2ws_result  out  XLEN  raw ALU result (for csr/badv use)
- ms2ws_payload  out  PAYLOAD_W  pass-through bus
- ms_fwd_we  out  1  forwarding: instruction in MEM writes rf (ANDed with valid)
- ms_fwd_waddr  out  5  forwarding destination register
- ms_fwd_wdata  out  XLEN  forwarding data
- ms_fwd_busy  out  1  load in MEM whose data is not yet available; ID must stall on a register match
- ms_ex  out  1  valid instruction in MEM carries an exception
- ws_ex  in  1  flush from WB

Behaviour:
- Reset (clk edge with resetn=0):
  - ms_valid=0, all captured fields=0, data_got=0, discard_cnt=0.
  - Hence ms2ws_valid, ms_fwd_we, ms_fwd_busy and ms_ex are 0; data outputs are 0.
- Valid register:
  - if ws_ex, ms_valid<=0;
  - else if ms_allowin, ms_valid<=es2ms_valid.
  - Fields are captured on es2ms_valid & ms_allowin & ~ws_ex.
- Handshake:
  - ms_allowin = ~ms_valid | (ms_ready_go & ws_allowin).
  - ms2ws_valid = ms_valid & ms_ready_go.
  - ms_ready_go = es2ms_ex | ~mem_req | data_got | live_ok.
  - live_ok = data_sram_data_ok & (discard_cnt==0).
- Response buffer:
  - If ms_valid & mem_req & ~data_got & live_ok & ~ws_allowin, latch rdata into data_buf and set data_got=1.
  - data_got clears when the instruction leaves, a new one enters, or on ws_ex.
  - Load data source = data_got ? data_buf : data_sram_rdata. Zero-latency pass-through when data_ok and ws_allowin coincide.
- Load extraction:
  - Offset = es2ms_result[log2(XLEN/8)-1:0]; shift load data right by offset*8.
  - Take the low 8/16/32/64 bits and extend with (ld_sign & top bit).
  - Size 3 with XLEN=32 yields 0.
  - rf_wdata = is_load ? extracted : result.
- Discard counter:
  - On ws_ex, inc = (ms_valid & mem_req & ~data_got & ~live_ok) + es_req_inflight.
  - A live_ok arriving in the same cycle as ws_ex is consumed and dropped, not counted.
  - Each data_ok while discard_cnt!=0 decrements and is dropped.
  - Increment and decrement in the same cycle sum.
  - Overflow past 2^DISCARD_W-1 is illegal; the bench asserts it never happens.
- Forwarding:
  - ms_fwd_we = ms_valid & rf_we; ms_fwd_wdata = rf_wdata.
  - ms_fwd_busy = ms_valid & is_load & rf_we & ~ms_ready_go.
- Exception:
  - ms_ex = ms_valid & es2ms_ex; the stage never waits on data for an excepting instruction.
- ms2ws_rf_we = rf_we & ~es2ms_ex (captured).

Test Plan:
- XLEN=32: ld.b with signed load, addr 0x1003, data_ok 3 cycles later with rdata 0x80FF_1234 → ms_fwd_busy=1 for 3 cycles, then ms2ws_rf_wdata=0xFFFF_FF80, ms2ws_valid 1 cycle.
- ld.hu, addr offset 2, data_ok arrives while ws_allowin=0 for 2 cycles, rdata 0xBEEF_0000 → buffered; wdata=0x0000_BEEF when ws_allowin rises; no data loss.
- ws_ex while MEM waits on a load and es_req_inflight=1 → discard_cnt=2; next two data_ok ignored; third data_ok completes a new load correctly.
- ws_ex coincident with data_ok for the MEM load → discard_cnt stays 0; ms_valid=0 next cycle.
- Store followed by ALU op: store ready on data_ok; ALU op (es2ms_mem_req=0) passes in 1 cycle with wdata=result; ms_fwd_busy=0.
- XLEN=64: ld.w signed at offset 4, rdata 0x8000_0001_0000_0000 → wdata 0xFFFF_FFFF_8000_0001; reset mid-wait clears all outputs to 0.
